// File: rtl/spi_dev_memrd_if.sv
// rtl/spi_dev_memrd_if.sv - SPI byte stream, memif read channel and Wishbone bundle for spi_dev_memrd
interface spi_dev_memrd_if;
    logic [7:0]  pw_wdata;
    logic        pw_wcmd;
    logic        pw_wstb;
    logic        pw_end;
    logic        pw_req;
    logic        pw_gnt;
    logic [7:0]  pw_rdata;
    logic        pw_rstb;

    logic [31:0] mi_addr;
    logic [6:0]  mi_len;
    logic        mi_rw;
    logic        mi_valid;
    logic        mi_ready;
    logic [15:0] mi_wdata;
    logic        mi_wack;
    logic        mi_wlast;
    logic [15:0] mi_rdata;
    logic        mi_rstb;
    logic        mi_rlast;

    logic [31:0] wb_wdata;
    logic [31:0] wb_rdata;
    logic [1:0]  wb_addr;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;

    modport slave (
        input  pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_gnt, pw_rstb,
        output pw_req, pw_rdata,
        output mi_addr, mi_len, mi_rw, mi_valid, mi_wdata,
        input  mi_ready, mi_wack, mi_wlast, mi_rdata, mi_rstb, mi_rlast,
        input  wb_wdata, wb_addr, wb_we, wb_cyc,
        output wb_rdata, wb_ack
    );

    modport master (
        output pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_gnt, pw_rstb,
        input  pw_req, pw_rdata,
        input  mi_addr, mi_len, mi_rw, mi_valid, mi_wdata,
        output mi_ready, mi_wack, mi_wlast, mi_rdata, mi_rstb, mi_rlast,
        output wb_wdata, wb_addr, wb_we, wb_cyc,
        input  wb_rdata, wb_ack
    );
endinterface

// File: rtl/spi_dev_memrd.sv
// rtl/spi_dev_memrd.sv - SPI memory-read device: 16-word burst prefetch into a 32x16 FIFO, streamed out low byte first
// Optional underrun-event counter at Wishbone addr 2 when SPI_DEV_MEMRD_STATS_EN is defined.
module spi_dev_memrd (
    input  logic             clk,
    input  logic             rst_n,
    spi_dev_memrd_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;

    state_t      r_state;
    logic [15:0] r_mem [0:31];
    logic [4:0]  r_wr_ptr, r_rd_ptr;
    logic [5:0]  r_level;
    logic [23:0] r_ptr, r_pend_ptr;
    logic        r_pend, r_discard, r_armed, r_underrun, r_bsel, r_pw_req;
    logic        r_cyc_d, r_wb_ack;
    logic [31:0] r_wb_rdata, r_mi_addr;
    logic [6:0]  r_mi_len;
    logic        r_mi_valid, r_mi_rw;

    logic        w_busy, w_wb_go, w_wr0, w_wr0_now, w_wr0_defer, w_apply;
    logic        w_last, w_push, w_pop, w_flush, w_empty, w_uflow;
    logic [15:0] w_head, w_stat;
    logic [31:0] w_rd_mux;

    assign w_busy      = (r_state != S_IDLE);
    assign w_wb_go     = bus.wb_cyc & ~r_cyc_d;
    assign w_wr0       = w_wb_go & bus.wb_we & (bus.wb_addr == 2'd0);
    assign w_wr0_now   = w_wr0 & ~w_busy;
    // A burst in flight cannot be cancelled, so a pointer rewrite waits until it drains.
    assign w_wr0_defer = w_wr0 & w_busy;
    assign w_apply     = r_pend & (r_state == S_IDLE);
    assign w_last      = (r_state == S_DATA) & bus.mi_rstb & bus.mi_rlast;
    assign w_flush     = bus.pw_end | w_wr0_now | w_apply;
    assign w_push      = (r_state == S_DATA) & bus.mi_rstb & ~r_discard & ~w_wr0_defer & ~bus.pw_end;
    assign w_empty     = (r_level == 6'd0);
    assign w_pop       = bus.pw_rstb & ~w_empty & r_bsel;
    assign w_uflow     = bus.pw_rstb & w_empty;
    assign w_head      = r_mem[r_rd_ptr];

    assign bus.pw_req   = r_pw_req;
    assign bus.pw_rdata = w_empty ? 8'h00 : (r_bsel ? w_head[15:8] : w_head[7:0]);
    assign bus.mi_addr  = r_mi_addr;
    assign bus.mi_len   = r_mi_len;
    assign bus.mi_rw    = r_mi_rw;
    assign bus.mi_valid = r_mi_valid;
    assign bus.mi_wdata = 16'h0000;
    assign bus.wb_ack   = r_wb_ack;
    assign bus.wb_rdata = r_wb_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mi_valid <= 1'b0;
            r_mi_rw    <= 1'b0;
            r_mi_len   <= 7'd0;
            r_mi_addr  <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: if (r_armed && r_level <= 6'd16 && !r_pend && !w_flush && !w_wr0) begin
                    r_state    <= S_REQ;
                    r_mi_valid <= 1'b1;
                    r_mi_rw    <= 1'b1;
                    r_mi_len   <= 7'd15;
                    r_mi_addr  <= {8'h00, r_ptr};
                end
                S_REQ: if (bus.mi_ready) begin
                    r_state    <= S_DATA;
                    r_mi_valid <= 1'b0;
                    r_mi_rw    <= 1'b0;
                    r_mi_len   <= 7'd0;
                end
                S_DATA: if (w_last) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= 24'h0;
            r_pend_ptr <= 24'h0;
            r_pend     <= 1'b0;
            r_discard  <= 1'b0;
            r_armed    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_wr0_now)       r_ptr <= bus.wb_wdata[23:0];
            else if (w_apply)    r_ptr <= r_pend_ptr;
            else if (w_last)     r_ptr <= r_ptr + 24'd16;

            if (w_wr0_defer) begin
                r_pend     <= 1'b1;
                r_pend_ptr <= bus.wb_wdata[23:0];
            end else if (w_apply) begin
                r_pend     <= 1'b0;
            end

            if (w_last)                                  r_discard <= 1'b0;
            else if (w_wr0_defer || (bus.pw_end && w_busy)) r_discard <= 1'b1;

            if (w_wr0_now || w_apply) r_armed <= 1'b1;
            else if (bus.pw_end)      r_armed <= 1'b0;

            if (w_wr0_now || w_apply) r_underrun <= 1'b0;
            else if (w_uflow)         r_underrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.mi_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 5'd0;
            r_rd_ptr <= 5'd0;
            r_level  <= 6'd0;
            r_bsel   <= 1'b0;
        end else if (w_flush) begin
            r_wr_ptr <= 5'd0;
            r_rd_ptr <= 5'd0;
            r_level  <= 6'd0;
            r_bsel   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 5'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 5'd1;
            r_level <= r_level + {5'd0, w_push} - {5'd0, w_pop};
            if (bus.pw_rstb && !w_empty) r_bsel <= ~r_bsel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                               r_pw_req <= 1'b0;
        else if (bus.pw_end)                                      r_pw_req <= 1'b0;
        else if (bus.pw_wstb && bus.pw_wcmd && bus.pw_wdata == 8'hF8) r_pw_req <= 1'b1;
    end

`ifdef SPI_DEV_MEMRD_STATS_EN
    logic [15:0] r_ucnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                             r_ucnt <= 16'h0;
        else if (w_wb_go && bus.wb_we && bus.wb_addr == 2'd2)   r_ucnt <= 16'h0;
        else if (w_uflow && r_ucnt != 16'hFFFF)                 r_ucnt <= r_ucnt + 16'd1;
    end
    assign w_stat = r_ucnt;
`else
    assign w_stat = 16'h0000;
`endif

    always_comb begin
        w_rd_mux = 32'h0;
        case (bus.wb_addr)
            2'd0: w_rd_mux = {8'h00, r_ptr};
            2'd1: w_rd_mux = {16'h0, 2'b00, r_level, 5'b0, r_underrun, w_busy, r_armed};
            2'd2: w_rd_mux = {16'h0, w_stat};
            default: w_rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_d    <= 1'b0;
            r_wb_ack   <= 1'b0;
            r_wb_rdata <= 32'h0;
        end else begin
            r_cyc_d    <= bus.wb_cyc;
            r_wb_ack   <= w_wb_go;
            r_wb_rdata <= (w_wb_go && !bus.wb_we) ? w_rd_mux : 32'h0;
        end
    end

    logic w_unused;
    assign w_unused = ^{bus.pw_gnt, bus.mi_wack, bus.mi_wlast, bus.wb_wdata[31:24]};
endmodule

// File: tb/tb_spi_dev_memrd.sv
// tb/tb_spi_dev_memrd.sv - directed self-checking bench for spi_dev_memrd
module tb_spi_dev_memrd;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   valid_seen;
    logic [31:0] rd;

    spi_dev_memrd_if bus ();

    spi_dev_memrd dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mword(input logic [23:0] a);
        return a[15:0] ^ 16'hBFEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        bus.wb_cyc = 1'b1; bus.wb_we = 1'b1; bus.wb_addr = a; bus.wb_wdata = d;
        tick;
        chk("wb_write_ack", {31'd0, bus.wb_ack}, 32'd1);
        bus.wb_cyc = 1'b0; bus.wb_we = 1'b0;
        tick;
        chk("wb_write_ack_drop", {31'd0, bus.wb_ack}, 32'd0);
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        bus.wb_cyc = 1'b1; bus.wb_we = 1'b0; bus.wb_addr = a;
        tick;
        chk("wb_read_ack", {31'd0, bus.wb_ack}, 32'd1);
        d = bus.wb_rdata;
        bus.wb_cyc = 1'b0;
        tick;
        chk("wb_rdata_idle", bus.wb_rdata, 32'd0);
    endtask

    task automatic wait_req(input string tag, input logic [23:0] a);
        int n;
        n = 0;
        while (!bus.mi_valid && n < 50) begin
            tick;
            n++;
        end
        chk({tag, "_valid"}, {31'd0, bus.mi_valid}, 32'd1);
        chk({tag, "_addr"}, bus.mi_addr, {8'h00, a});
        chk({tag, "_len"}, {25'd0, bus.mi_len}, 32'd15);
        chk({tag, "_rw"}, {31'd0, bus.mi_rw}, 32'd1);
    endtask

    task automatic grant;
        bus.mi_ready = 1'b1;
        tick;
        bus.mi_ready = 1'b0;
    endtask

    task automatic stream(input logic [23:0] base, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            bus.mi_rdata = mword(base + 24'(i));
            bus.mi_rstb  = 1'b1;
            bus.mi_rlast = (i == 15);
            tick;
            if (bus.mi_valid) valid_seen++;
        end
        bus.mi_rstb  = 1'b0;
        bus.mi_rlast = 1'b0;
    endtask

    task automatic spi_cmd(input logic [7:0] c);
        bus.pw_wdata = c; bus.pw_wcmd = 1'b1; bus.pw_wstb = 1'b1;
        tick;
        bus.pw_wcmd = 1'b0; bus.pw_wstb = 1'b0;
    endtask

    task automatic spi_rstb;
        bus.pw_rstb = 1'b1;
        tick;
        bus.pw_rstb = 1'b0;
    endtask

    task automatic spi_end;
        bus.pw_end = 1'b1;
        tick;
        bus.pw_end = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.pw_wdata = 8'h00; bus.pw_wcmd = 1'b0; bus.pw_wstb = 1'b0; bus.pw_end = 1'b0;
        bus.pw_gnt = 1'b0; bus.pw_rstb = 1'b0;
        bus.mi_ready = 1'b0; bus.mi_wack = 1'b0; bus.mi_wlast = 1'b0;
        bus.mi_rdata = 16'h0; bus.mi_rstb = 1'b0; bus.mi_rlast = 1'b0;
        bus.wb_wdata = 32'h0; bus.wb_addr = 2'd0; bus.wb_we = 1'b0; bus.wb_cyc = 1'b0;
        valid_seen = 0;

        // reset state
        tick; tick;
        chk("rst_pw_req", {31'd0, bus.pw_req}, 32'd0);
        chk("rst_pw_rdata", {24'd0, bus.pw_rdata}, 32'd0);
        chk("rst_mi_valid", {31'd0, bus.mi_valid}, 32'd0);
        chk("rst_mi_addr", bus.mi_addr, 32'd0);
        chk("rst_mi_len", {25'd0, bus.mi_len}, 32'd0);
        chk("rst_mi_rw", {31'd0, bus.mi_rw}, 32'd0);
        chk("rst_wb_ack", {31'd0, bus.wb_ack}, 32'd0);
        chk("rst_wb_rdata", bus.wb_rdata, 32'd0);
        chk("mi_wdata_tied", {16'd0, bus.mi_wdata}, 32'd0);
        rst_n = 1'b1;
        tick;
        wb_read(2'd1, rd); chk("rst_status", rd, 32'h0);
        wb_read(2'd0, rd); chk("rst_ptr", rd, 32'h0);
        wb_write(2'd3, 32'hFFFF_FFFF);
        wb_read(2'd3, rd); chk("addr3_zero", rd, 32'h0);

        // two bursts fill the FIFO, no third
        wb_write(2'd0, 32'h0000_0100);
        wait_req("req1", 24'h000100);
        grant;
        chk("req1_valid_drop", {31'd0, bus.mi_valid}, 32'd0);
        stream(24'h000100, 0, 15);
        wait_req("req2", 24'h000110);
        grant;
        stream(24'h000110, 0, 15);
        valid_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (bus.mi_valid) valid_seen++;
        end
        chk("no_third_req", valid_seen, 32'd0);
        wb_read(2'd1, rd); chk("status_full", rd, 32'h0000_2001);

        // byte stream out, low byte first
        spi_cmd(8'h03);
        chk("cmd_other_ignored", {31'd0, bus.pw_req}, 32'd0);
        spi_cmd(8'hF8);
        chk("cmd_f8_req", {31'd0, bus.pw_req}, 32'd1);
        chk("byte0", {24'd0, bus.pw_rdata}, 32'h0000_00EF);
        spi_rstb;
        chk("byte1", {24'd0, bus.pw_rdata}, 32'h0000_00BE);
        spi_rstb;
        chk("byte2", {24'd0, bus.pw_rdata}, 32'h0000_00EE);
        wb_read(2'd1, rd); chk("status_after_pop", rd, 32'h0000_1F01);
        spi_end;
        chk("end_pw_req", {31'd0, bus.pw_req}, 32'd0);
        wb_read(2'd1, rd); chk("status_after_end", rd, 32'h0);

        // underrun without arming
        spi_cmd(8'hF8);
        for (int i = 0; i < 3; i++) begin
            chk("underrun_byte", {24'd0, bus.pw_rdata}, 32'd0);
            spi_rstb;
        end
        chk("underrun_byte_last", {24'd0, bus.pw_rdata}, 32'd0);
        wb_read(2'd1, rd); chk("status_underrun", rd, 32'h0000_0004);
        wb_read(2'd2, rd);
`ifdef SPI_DEV_MEMRD_STATS_EN
        chk("stats_count", rd, 32'd3);
`else
        chk("stats_absent", rd, 32'd0);
`endif
        wb_write(2'd2, 32'h0);
        wb_read(2'd2, rd); chk("stats_cleared", rd, 32'd0);
        spi_end;

        // transaction end mid-burst
        wb_write(2'd0, 32'h0000_0300);
        spi_cmd(8'hF8);
        wait_req("req300", 24'h000300);
        grant;
        stream(24'h000300, 0, 4);
        spi_end;
        chk("midend_pw_req", {31'd0, bus.pw_req}, 32'd0);
        wb_read(2'd1, rd); chk("midend_status_busy", rd, 32'h0000_0002);
        stream(24'h000300, 5, 15);
        tick;
        wb_read(2'd1, rd); chk("midend_status_idle", rd, 32'h0);
        valid_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (bus.mi_valid) valid_seen++;
        end
        chk("midend_no_req", valid_seen, 32'd0);

        // deferred pointer rewrite during DATA
        wb_write(2'd0, 32'h0000_0400);
        wait_req("req400", 24'h000400);
        grant;
        stream(24'h000400, 0, 3);
        wb_write(2'd0, 32'h0000_0200);
        valid_seen = 0;
        stream(24'h000400, 4, 15);
        chk("defer_no_req", valid_seen, 32'd0);
        wb_read(2'd1, rd); chk("defer_level_held", rd, 32'h0000_0401);
        wait_req("req200", 24'h000200);
        wb_read(2'd1, rd); chk("defer_flushed", rd, 32'h0000_0003);
        wb_read(2'd0, rd); chk("defer_ptr", rd, 32'h0000_0200);

        // asynchronous reset while a request is pending
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, bus.mi_valid}, 32'd0);
        chk("async_rst_addr", bus.mi_addr, 32'd0);
        tick;
        rst_n = 1'b1;
        tick;
        wb_read(2'd1, rd); chk("post_rst_status", rd, 32'h0);

        // pointer wrap at 24 bits
        wb_write(2'd0, 32'h00FF_FFF0);
        wait_req("reqfff0", 24'hFFFFF0);
        grant;
        stream(24'hFFFFF0, 0, 15);
        wait_req("reqwrap", 24'h000000);
        wb_read(2'd0, rd); chk("wrap_ptr", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_dev_memrd.md
SPI_DEV_MEMRD -- requirements
Module: spi_dev_memrd

Interface
REQ-001 SHALL have port clk, input, 1, single clock for all logic.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have ports pw_wdata (input, 8), pw_wcmd (input, 1) and pw_wstb (input, 1): SPI protocol byte stream; pw_wcmd marks the command byte.
REQ-004 SHALL have port pw_end, input, 1, pulse at SPI transaction end (CS rise).
REQ-005 SHALL have ports pw_req (output, 1), pw_gnt (input, 1), pw_rdata (output, 8) and pw_rstb (input, 1): response claim, grant, MISO byte, and byte-consumed pulse.
REQ-006 SHALL have ports mi_addr (output, 32), mi_len (output, 7), mi_rw (output, 1), mi_valid (output, 1) and mi_ready (input, 1): memif request channel; word address; len = words-1; mi_rw=1 means read.
REQ-007 SHALL have ports mi_wdata (output, 16), mi_wack (input, 1) and mi_wlast (input, 1); mi_wdata is tied to 0 and mi_wack/mi_wlast are ignored.
REQ-008 SHALL have ports mi_rdata (input, 16), mi_rstb (input, 1) and mi_rlast (input, 1): memif read data, strobe, and last-word marker.
REQ-009 SHALL have ports wb_wdata (input, 32), wb_rdata (output, 32), wb_addr (input, 2), wb_we (input, 1), wb_cyc (input, 1) and wb_ack (output, 1): Wishbone register slave.

Function
REQ-010 SHALL contain a 32x16-bit prefetch FIFO with a 6-bit level count (0..32).
REQ-011 SHALL write word address bits [23:0] on a Wishbone write to addr 0; this latches the fetch pointer, flushes the FIFO, clears the underrun flag and sets armed=1.
REQ-012 SHALL run a fetch FSM with states IDLE, REQ and DATA: IDLE->REQ when armed and level<=16; REQ holds mi_valid=1, mi_rw=1 and mi_len=15 with stable mi_addr={8'h00,ptr}, going REQ->DATA on mi_ready; DATA pushes one word per mi_rstb and goes DATA->IDLE on mi_rstb&mi_rlast, adding 16 to ptr with 24-bit wrap.
REQ-013 SHALL complete a burst once mi_ready has been seen, accepting all 16 words even if disarmed or flushed meanwhile; words arriving after a flush request are discarded.
REQ-014 SHALL defer a Wishbone addr 0 write that arrives during REQ-after-ready or DATA: the new pointer is applied, and the FIFO flushed, on the cycle after rlast.
REQ-015 SHALL set pw_req=1 from the cycle after pw_wstb&pw_wcmd with pw_wdata=8'hF8 until pw_end; other command bytes are ignored.
REQ-016 SHALL output bytes low byte first: pw_rdata = head word [7:0], then [15:8]; pw_rstb advances the byte selector, and the FIFO pops after the high byte.
REQ-017 SHALL, when pw_rstb occurs with the FIFO empty, output pw_rdata=8'h00, leave the selector unchanged and set the sticky underrun flag.
REQ-018 SHALL handle a push and a pop in the same cycle with the level unchanged; a push at level 32 cannot occur by REQ-012.
REQ-019 SHALL, on pw_end, deassert pw_req, clear armed and flush the FIFO, honouring REQ-013.
REQ-020 SHALL pulse wb_ack for one cycle, 1 cycle after wb_cyc rises, and drive wb_rdata=0 when wb_ack=0.
REQ-021 SHALL map reads as follows: addr 0 = {8'h00,ptr}; addr 1 = {16'h0, level(8), 5'b0, underrun, busy(FSM!=IDLE), armed}; addr 3 reads 0; writes to addr 1 and 3 are ignored.

Reset
REQ-022 SHALL, while rst_n=0, hold pw_req=0, pw_rdata=0, mi_valid=0, mi_addr=0, mi_len=0, mi_rw=0, wb_ack=0, wb_rdata=0, the FSM in IDLE, level=0, ptr=0, armed=0 and underrun=0.
REQ-023 SHALL take effect immediately when reset is asserted mid-burst, with no completion of the burst; the memif arbiter is reset together with this block.

Configuration
REQ-024 SHALL, with SPI_DEV_MEMRD_STATS_EN defined, implement a 16-bit saturating underrun-event counter at Wishbone addr 2 that is cleared by any write there.
REQ-025 SHALL, without SPI_DEV_MEMRD_STATS_EN, read addr 2 as 0, ignore writes to it, and build no counter logic.

Verification
REQ-026 SHALL cover: WB write addr0=0x000100 -> one request with mi_addr=0x100 and mi_len=15, then a second at 0x110, level settling at 32, and no third request.
REQ-027 SHALL cover: the memory word at 0x100=0xBEEF, cmd 0xF8, then 2 pw_rstb -> pw_rdata sequence 0xEF, 0xBE, then the next word's low byte.
REQ-028 SHALL cover: cmd 0xF8 with no arm, then 3 pw_rstb -> three 0x00 bytes, status underrun=1, and with STATS_EN the addr2 read = 3.
REQ-029 SHALL cover: pw_end mid-DATA (word 5 of 16) -> the remaining 11 words are accepted, then level=0, armed=0, pw_req=0 and the FSM is IDLE.
REQ-030 SHALL cover: addr0 rewrite to 0x000200 during DATA -> no new request before rlast, the FIFO is flushed after rlast, and the next mi_addr=0x200.
REQ-031 SHALL cover: ptr=0xFFFFF0 after one burst -> ptr=0x000000, and rst_n low mid-REQ -> mi_valid=0 in the same cycle.
